// File: rtl/muldiv_if.sv
// Handshake and operand/result bundle between a requester (master) and the
// iterative multiply/divide unit (slave).
interface muldiv_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [1:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] w;
   logic             zero;

   modport master (output start, op, a, b, input busy, done, w, zero);
   modport slave  (input start, op, a, b, output busy, done, w, zero);
endinterface

// File: rtl/muldiv_unit.sv
// Iterative radix-2 signed multiply (MUL/MULH) and restoring divide (DIV/REM).
// Fixed 33-cycle busy window, one-cycle done pulse, result held in w.
module muldiv_unit #(
   parameter int WIDTH = 32
) (
   input  logic     clk,
   input  logic     rst,
   muldiv_if.slave  bus
);
   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             fin_q, fin_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic [WIDTH-1:0] opnd_q, opnd_d;
   logic [1:0]       op_q, op_d;
   logic             sa_q, sa_d;
   logic             sb_q, sb_d;
   logic [WIDTH-1:0] w_q, w_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic [WIDTH-1:0]   abs_a, abs_b;
   logic [WIDTH:0]     mul_sum;
   logic [WIDTH:0]     div_shift;
   logic [WIDTH-1:0]   div_sub;
   logic               div_borrow;
   logic [2*WIDTH-1:0] prod, prod_s;
   logic [WIDTH-1:0]   quo_s, rem_s;
   logic [WIDTH-1:0]   res;

   assign abs_a = bus.a[WIDTH-1] ? -bus.a : bus.a;
   assign abs_b = bus.b[WIDTH-1] ? -bus.b : bus.b;

   // Multiply: hi:lo holds partial product over the multiplier, shifted right each step.
   assign mul_sum = {1'b0, hi_q} + {1'b0, (lo_q[0] ? opnd_q : '0)};

   // Divide: hi is the partial remainder, lo shifts dividend bits out and quotient bits in.
   assign div_shift  = {hi_q, lo_q[WIDTH-1]};
   assign div_borrow = div_shift < {1'b0, opnd_q};
   assign div_sub    = div_shift[WIDTH-1:0] - opnd_q;

   assign prod   = {hi_q, lo_q};
   assign prod_s = (sa_q ^ sb_q) ? -prod : prod;
   assign quo_s  = (sa_q ^ sb_q) ? -lo_q : lo_q;
   assign rem_s  = sa_q ? -hi_q : hi_q;

   always_comb begin
      res = prod_s[WIDTH-1:0];
      case (op_q)
         2'b00: res = prod_s[WIDTH-1:0];
         2'b01: res = prod_s[2*WIDTH-1:WIDTH];
         2'b10: res = (opnd_q == '0) ? '1 : quo_s;
         2'b11: res = rem_s;
         default: res = prod_s[WIDTH-1:0];
      endcase
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      fin_d   = fin_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      opnd_d  = opnd_q;
      op_d    = op_q;
      sa_d    = sa_q;
      sb_d    = sb_q;
      w_d     = w_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            busy_d = 1'b0;
            if (bus.start) begin
               state_d = CALC;
               busy_d  = 1'b1;
               op_d    = bus.op;
               sa_d    = bus.a[WIDTH-1];
               sb_d    = bus.b[WIDTH-1];
               cnt_d   = '0;
               fin_d   = 1'b0;
               hi_d    = '0;
               lo_d    = bus.op[1] ? abs_a : abs_b;
               opnd_d  = bus.op[1] ? abs_b : abs_a;
            end
         end
         CALC: begin
            if (!fin_q) begin
               if (op_q[1]) begin
                  hi_d = div_borrow ? div_shift[WIDTH-1:0] : div_sub;
                  lo_d = {lo_q[WIDTH-2:0], ~div_borrow};
               end else begin
                  hi_d = mul_sum[WIDTH:1];
                  lo_d = {mul_sum[0], lo_q[WIDTH-1:1]};
               end
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == LAST) fin_d = 1'b1;
            end else begin
               // Final CALC cycle applies sign correction into the result register.
               w_d     = res;
               state_d = DONE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               fin_d   = 1'b0;
            end
         end
         DONE: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         fin_q   <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
         opnd_q  <= '0;
         op_q    <= '0;
         sa_q    <= 1'b0;
         sb_q    <= 1'b0;
         w_q     <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         fin_q   <= fin_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         opnd_q  <= opnd_d;
         op_q    <= op_d;
         sa_q    <= sa_d;
         sb_q    <= sb_d;
         w_q     <= w_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.w    = w_q;
   assign bus.zero = ~|w_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit: latency, arithmetic corner
// cases, ignored start while busy, back-to-back start and mid-operation reset.
module tb_muldiv_unit;
   logic clk;
   logic rst;
   int   n_tests;
   int   n_fail;

   muldiv_if #(.WIDTH(32)) dut_if ();

   muldiv_unit #(.WIDTH(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (dut_if.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Called at a negedge; returns at the negedge after the cycle following done.
   // glitch > 0 pulses a junk start so that it is sampled at edge E<glitch>.
   task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_w, input int glitch);
      int bad_span;
      bad_span = 0;
      dut_if.start = 1'b1;
      dut_if.op    = op;
      dut_if.a     = a;
      dut_if.b     = b;
      @(posedge clk);
      #1;
      dut_if.start = 1'b0;
      dut_if.a     = ~a ^ 32'h5A5A_1234;
      dut_if.b     = b + 32'd77;
      for (int i = 0; i <= 32; i++) begin
         @(negedge clk);
         if (!(dut_if.busy === 1'b1 && dut_if.done === 1'b0)) bad_span++;
         if (glitch > 0 && i == glitch - 1) begin
            dut_if.start = 1'b1;
            dut_if.op    = 2'b00;
            dut_if.a     = 32'd2;
            dut_if.b     = 32'd2;
         end
         if (glitch > 0 && i == glitch) dut_if.start = 1'b0;
      end
      check({name, " busy_span"}, 32'(bad_span), 32'd0);
      @(negedge clk);
      check({name, " done"}, 32'(dut_if.done), 32'd1);
      check({name, " busy_at_done"}, 32'(dut_if.busy), 32'd0);
      check({name, " w"}, dut_if.w, exp_w);
      check({name, " zero"}, 32'(dut_if.zero), 32'(exp_w == 32'd0));
      $display("[TB] %s a=0x%08h b=0x%08h w=0x%08h expected 0x%08h", name, a, b, dut_if.w, exp_w);
      @(negedge clk);
      check({name, " done_cleared"}, 32'(dut_if.done), 32'd0);
      check({name, " w_held"}, dut_if.w, exp_w);
   endtask

   initial begin
      int done_seen;
      int busy_seen;
      n_tests      = 0;
      n_fail       = 0;
      rst          = 1'b1;
      dut_if.start = 1'b0;
      dut_if.op    = 2'b00;
      dut_if.a     = '0;
      dut_if.b     = '0;
      repeat (3) @(negedge clk);
      check("reset busy", 32'(dut_if.busy), 32'd0);
      check("reset done", 32'(dut_if.done), 32'd0);
      check("reset w", dut_if.w, 32'd0);
      check("reset zero", 32'(dut_if.zero), 32'd1);
      rst = 1'b0;
      @(negedge clk);
      check("idle busy", 32'(dut_if.busy), 32'd0);

      run_op("MUL 7*-3",          2'b00, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 0);
      run_op("MULH min*min",      2'b01, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 0);
      run_op("MULH -1*1",         2'b01, 32'hFFFF_FFFF,  32'd1,         32'hFFFF_FFFF, 0);
      run_op("MULH max*max",      2'b01, 32'h7FFF_FFFF,  32'h7FFF_FFFF, 32'h3FFF_FFFF, 0);
      run_op("MUL -5*-6",         2'b00, 32'hFFFF_FFFB,  32'hFFFF_FFFA, 32'd30,        0);
      run_op("DIV -7/2",          2'b10, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 0);
      run_op("REM -7%2",          2'b11, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 0);
      run_op("REM 7%-2",          2'b11, 32'd7,          32'hFFFF_FFFE, 32'd1,         0);
      run_op("DIV -100/7",        2'b10, 32'hFFFF_FF9C,  32'd7,         32'hFFFF_FFF2, 0);
      run_op("REM -100%7",        2'b11, 32'hFFFF_FF9C,  32'd7,         32'hFFFF_FFFE, 0);
      run_op("DIV 5/0",           2'b10, 32'd5,          32'd0,         32'hFFFF_FFFF, 0);
      run_op("REM 5%0",           2'b11, 32'd5,          32'd0,         32'd5,         0);
      run_op("DIV min/-1",        2'b10, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 0);
      run_op("REM min%-1",        2'b11, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         0);
      run_op("DIV 100/7 glitch",  2'b10, 32'd100,        32'd7,         32'd14,        10);
      run_op("MUL back2back",     2'b00, 32'd9,          32'd11,        32'd99,        0);

      // Abort a MUL with an asynchronous reset pulse shortly after edge E15.
      dut_if.start = 1'b1;
      dut_if.op    = 2'b00;
      dut_if.a     = 32'd1234;
      dut_if.b     = 32'd5678;
      @(posedge clk);
      #1;
      dut_if.start = 1'b0;
      repeat (15) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("abort busy", 32'(dut_if.busy), 32'd0);
      check("abort done", 32'(dut_if.done), 32'd0);
      check("abort w", dut_if.w, 32'd0);
      check("abort zero", 32'(dut_if.zero), 32'd1);
      @(negedge clk);
      rst = 1'b0;
      done_seen = 0;
      busy_seen = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (dut_if.done === 1'b1) done_seen++;
         if (dut_if.busy === 1'b1) busy_seen++;
      end
      check("abort no_done", 32'(done_seen), 32'd0);
      check("abort no_busy", 32'(busy_seen), 32'd0);
      $display("[TB] reset abort: done pulses=%0d busy cycles=%0d", done_seen, busy_seen);

      run_op("MUL 3*4 after rst", 2'b00, 32'd3, 32'd4, 32'd12, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
